// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port RAM arbiter: FSM encoding and port indices.
package ram_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    RESP = ST_RESP
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/rr_grant2.sv
// Combinational 2-way winner selection; the parent registers the result.
module rr_grant2
  import ram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic       any,
  output logic       winner
);

  // A tie goes to the port that did not win last time, or to the CPU when prioritised.
  always_comb begin
    any    = |valid;
    winner = PORT_CPU;
    if (valid == 2'b11) begin
      winner = fixed_prio ? PORT_CPU : ~last_grant;
    end else if (valid[1]) begin
      winner = PORT_DMA;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises CPU (port 0) and DMA (port 1) requests onto the single-ported RAM,
// routes completion and read data back to the owner and aborts stalled accesses.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 32,
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      p0_valid,
  input  logic                      p0_write,
  input  logic [ADDRESS_BITS-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]     p0_wdata,
  input  logic [DATA_WIDTH/8-1:0]   p0_wstrb,
  output logic                      p0_ready,
  output logic                      p0_done,
  output logic [DATA_WIDTH-1:0]     p0_rdata,
  output logic                      p0_err,
  input  logic                      p1_valid,
  input  logic                      p1_write,
  input  logic [ADDRESS_BITS-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]     p1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   p1_wstrb,
  output logic                      p1_ready,
  output logic                      p1_done,
  output logic [DATA_WIDTH-1:0]     p1_rdata,
  output logic                      p1_err,
  output logic                      ram_valid,
  output logic                      ram_write,
  output logic                      ram_read,
  output logic [ADDRESS_BITS-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  output logic [DATA_WIDTH/8-1:0]   ram_wstrb,
  input  logic [DATA_WIDTH-1:0]     ram_rdata,
  input  logic                      ram_done,
  output logic                      grant_o
);

  localparam int SW = DATA_WIDTH / 8;
  // Width keeps at least one bit so a disabled timeout still elaborates.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int MAX_INT  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST_INT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_INT);
  localparam logic FP = (FIXED_PRIO != 0);

  arb_state_e                      state_q, state_d;
  logic                            owner_q, owner_d;
  logic                            last_q, last_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            abort_q, abort_d;
  logic                            rv_q, rv_d;
  logic                            rw_q, rw_d;
  logic [ADDRESS_BITS-1:0]         ra_q, ra_d;
  logic [DATA_WIDTH-1:0]           rwd_q, rwd_d;
  logic [SW-1:0]                   rws_q, rws_d;
  logic [1:0]                      done_q, done_d;
  logic [1:0][DATA_WIDTH-1:0]      rdata_q, rdata_d;

  logic any;
  logic winner;

  rr_grant2 u_sel (
    .valid      ({p1_valid, p0_valid}),
    .last_grant (last_q),
    .fixed_prio (FP),
    .any        (any),
    .winner     (winner)
  );

  // Next-state, command latching, timeout counting and response routing.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    rv_d    = rv_q;
    rw_d    = rw_q;
    ra_d    = ra_q;
    rwd_d   = rwd_q;
    rws_d   = rws_q;
    done_d  = 2'b00;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        if (any) begin
          owner_d = winner;
          last_d  = winner;
          rv_d    = 1'b1;
          rw_d    = winner ? p1_write : p0_write;
          ra_d    = winner ? p1_addr  : p0_addr;
          rwd_d   = winner ? p1_wdata : p0_wdata;
          rws_d   = winner ? p1_wstrb : p0_wstrb;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (ram_done || (TIMEOUT_EN && (cnt_q == CNT_LAST))) begin
          // Completion wins over a timeout landing on the same edge.
          if (ram_done) begin
            if (!rw_q) begin
              rdata_d[owner_q] = ram_rdata;
            end
          end else begin
            abort_d = 1'b1;
          end
          rv_d             = 1'b0;
          rw_d             = 1'b0;
          ra_d             = '0;
          rwd_d            = '0;
          rws_d            = '0;
          done_d[owner_q]  = 1'b1;
          state_d          = RESP;
        end
      end
      RESP: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      owner_q <= PORT_CPU;
      last_q  <= PORT_DMA;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      rv_q    <= 1'b0;
      rw_q    <= 1'b0;
      ra_q    <= '0;
      rwd_q   <= '0;
      rws_q   <= '0;
      done_q  <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      rv_q    <= rv_d;
      rw_q    <= rw_d;
      ra_q    <= ra_d;
      rwd_q   <= rwd_d;
      rws_q   <= rws_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign p0_ready  = (state_q == IDLE);
  assign p1_ready  = (state_q == IDLE);
  assign p0_done   = done_q[0];
  assign p1_done   = done_q[1];
  assign p0_err    = done_q[0] & abort_q;
  assign p1_err    = done_q[1] & abort_q;
  assign p0_rdata  = rdata_q[0];
  assign p1_rdata  = rdata_q[1];
  assign ram_valid = rv_q;
  assign ram_write = rv_q & rw_q;
  assign ram_read  = rv_q & ~rw_q;
  assign ram_addr  = ra_q;
  assign ram_wdata = rwd_q;
  assign ram_wstrb = rws_q;
  assign grant_o   = owner_q;

endmodule
